cf_fft_stage_mux: RTL and testbench
===================================

// Module: cf_fft_stage_mux
// PURPOSE
//  Parametrised, pipelined stage-sequenced source selector for the FFT datapath.
//  Routes one of NUM_SRC data channels to a single output on a fixed rotation (HOLD
//  samples per source), framed by sync_i. A software/test override can force any source.
//  Delays sync and the select index alongside the data, so downstream stages see an
//  aligned sample/sync/select triple.
// PARAMETERS
//  WIDTH    8  bits per data channel
//  NUM_SRC  4  number of source channels (>=2)
//  HOLD     2  consecutive samples taken from each source before advancing (>=1)
//  PIPE     2  output register stages = latency in enabled cycles (>=1)
//  SEL_W    2  select index width, >= clog2(NUM_SRC)
// PORTS
//  clock_c      in   1              clock; all state on rising edge
//  reset_i      in   1              synchronous, active-high reset
//  enable_i     in   1              clock enable; low = every register holds
//  sync_i       in   1              marks first sample of a frame
//  data_i       in   NUM_SRC*WIDTH  channel k = data_i[k*WIDTH +: WIDTH]
//  force_en_i   in   1              1 = use force_sel_i instead of the rotation
//  force_sel_i  in   SEL_W          forced source index
//  data_o       out  WIDTH          selected sample, PIPE cycles late
//  sync_o       out  1              sync_i delayed by PIPE
//  sel_o        out  SEL_W          source index actually used, delayed by PIPE
// BEHAVIOUR
//  - Reset: hold_cnt=0, sel_cnt=0, all pipeline regs=0 -> data_o=0, sync_o=0, sel_o=0.
//    Reset beats enable_i. Reset mid-frame discards in-flight samples.
//  - enable_i=0: counters and pipeline hold; inputs ignored; outputs stay constant.
//  - Per enabled cycle:
//    cur_sel  = sync_i ? 0 : sel_cnt;
//    cur_hold = sync_i ? 0 : hold_cnt.
//  - Advance: if cur_hold==HOLD-1 -> hold_cnt=0, sel_cnt = (cur_sel==NUM_SRC-1) ? 0 : cur_sel+1;
//    else hold_cnt = cur_hold+1, sel_cnt = cur_sel.
//  - Rotation free-runs: after the last source it wraps to 0 with no sync needed.
//    sync_i mid-frame restarts immediately at source 0, hold 0 (that sample uses source 0).
//  - Effective index:
//    use_sel = force_en_i ? force_sel_i : cur_sel;
//    if use_sel >= NUM_SRC, source 0 is used and sel_o reports 0.
//  - Force does not stop the counters: on release, the rotation is at the position
//    it would have reached anyway.
//  - Pipe stage 1 registers {channel[use_sel], sync_i, use_sel}; stages 2..PIPE shift.
//  - Latency is exactly PIPE enabled cycles for data_o, sync_o and sel_o alike.
//  - Pure selection: no arithmetic on data; width is preserved.
// TESTING
//  (WIDTH=8, NUM_SRC=4, HOLD=2, PIPE=2 unless noted; ch0..3 = 0x11,0x22,0x33,0x44)
//  1 Reset, then enable=1 with sync_i pulsed on cycle 0 ->
//    data_o from cycle 2: 11,11,22,22,33,33,44,44,11,...;
//    sync_o=1 only with the first 0x11; sel_o 0,0,1,1,2,2,3,3,0.
//  2 sync_i re-pulsed on the 4th sample (while ch1 active) -> that sample outputs 0x11;
//    the sequence restarts 11,11,22,...
//  3 enable_i low for 3 cycles mid-stream -> data_o/sync_o/sel_o frozen for those cycles;
//    the sequence resumes with no skipped or repeated sample.
//  4 force_en_i=1, force_sel_i=2 for 4 samples -> 0x33 and sel_o=2;
//    force_sel_i=5 -> 0x11 and sel_o=0; release -> rotation continues at the correct phase.
//  5 reset_i high for 1 cycle mid-stream with enable high -> next cycle data_o=0,
//    sync_o=0, sel_o=0; the first post-reset sample (no sync) comes from ch0.
//  6 Build NUM_SRC=3, HOLD=1, PIPE=1 -> source changes every cycle: 11,22,33,11,...
//    with latency 1.

Source files
------------

// File: rtl/cf_fft_stage_mux.sv
// cf_fft_stage_mux: stage-sequenced source selector for the FFT datapath.
// Picks one of NUM_SRC channels on a fixed rotation (HOLD samples per source),
// restarted by sync_i, with an optional forced source. The chosen sample, the
// sync flag and the index actually used travel together through PIPE register
// stages so downstream logic sees an aligned triple.
module cf_fft_stage_mux #(
    parameter int WIDTH   = 8,
    parameter int NUM_SRC = 4,
    parameter int HOLD    = 2,
    parameter int PIPE    = 2,
    parameter int SEL_W   = 2
) (
    input  logic                     clock_c,
    input  logic                     reset_i,
    input  logic                     enable_i,
    input  logic                     sync_i,
    input  logic [NUM_SRC*WIDTH-1:0] data_i,
    input  logic                     force_en_i,
    input  logic [SEL_W-1:0]         force_sel_i,
    output logic [WIDTH-1:0]         data_o,
    output logic                     sync_o,
    output logic [SEL_W-1:0]         sel_o
);

    localparam int HOLD_W = (HOLD > 1) ? $clog2(HOLD) : 1;
    localparam logic [HOLD_W-1:0] HOLD_LAST = HOLD_W'(HOLD - 1);
    localparam logic [SEL_W-1:0]  SEL_LAST  = SEL_W'(NUM_SRC - 1);
    // One extra bit so NUM_SRC == 2**SEL_W still compares correctly.
    localparam logic [SEL_W:0]    NUM_SRC_X = (SEL_W + 1)'(NUM_SRC);

    // Rotation position: sample count within the current source, and source index.
    logic [HOLD_W-1:0] hold_cnt_q, hold_cnt_d;
    logic [SEL_W-1:0]  sel_cnt_q, sel_cnt_d;

    logic [HOLD_W-1:0] cur_hold;
    logic [SEL_W-1:0]  cur_sel;
    logic [SEL_W-1:0]  use_sel;
    logic [SEL_W-1:0]  eff_sel;
    logic [WIDTH-1:0]  sel_data;

    // Output pipeline; index PIPE-1 drives the ports.
    logic [WIDTH-1:0] data_q [PIPE];
    logic             sync_q [PIPE];
    logic [SEL_W-1:0] sel_q  [PIPE];

    // Sync restarts the rotation on the very sample it marks; then advance.
    always_comb begin
        cur_sel    = sync_i ? '0 : sel_cnt_q;
        cur_hold   = sync_i ? '0 : hold_cnt_q;
        hold_cnt_d = cur_hold;
        sel_cnt_d  = cur_sel;
        if (cur_hold == HOLD_LAST) begin
            hold_cnt_d = '0;
            sel_cnt_d  = (cur_sel == SEL_LAST) ? '0 : cur_sel + 1'b1;
        end else begin
            hold_cnt_d = cur_hold + 1'b1;
        end
    end

    // Override only changes which channel is taken; the rotation keeps counting
    // underneath so releasing the force lands on the natural phase.
    always_comb begin
        use_sel = force_en_i ? force_sel_i : cur_sel;
        eff_sel = ({1'b0, use_sel} >= NUM_SRC_X) ? '0 : use_sel;
    end

    // Channel multiplexer over the flattened input bus.
    always_comb begin
        sel_data = '0;
        for (int k = 0; k < NUM_SRC; k++) begin
            if (eff_sel == SEL_W'(k)) begin
                sel_data = data_i[k*WIDTH +: WIDTH];
            end
        end
    end

    // Counters and pipeline advance together only on enabled cycles; reset wins.
    always_ff @(posedge clock_c) begin
        if (reset_i) begin
            hold_cnt_q <= '0;
            sel_cnt_q  <= '0;
            for (int i = 0; i < PIPE; i++) begin
                data_q[i] <= '0;
                sync_q[i] <= 1'b0;
                sel_q[i]  <= '0;
            end
        end else if (enable_i) begin
            hold_cnt_q <= hold_cnt_d;
            sel_cnt_q  <= sel_cnt_d;
            data_q[0]  <= sel_data;
            sync_q[0]  <= sync_i;
            sel_q[0]   <= eff_sel;
            for (int i = 1; i < PIPE; i++) begin
                data_q[i] <= data_q[i-1];
                sync_q[i] <= sync_q[i-1];
                sel_q[i]  <= sel_q[i-1];
            end
        end
    end

    assign data_o = data_q[PIPE-1];
    assign sync_o = sync_q[PIPE-1];
    assign sel_o  = sel_q[PIPE-1];

endmodule

// File: tb/tb_cf_fft_stage_mux.sv
// Bench for cf_fft_stage_mux: two builds driven by the same control stimulus,
// (4 sources, HOLD 2, PIPE 2, 3-bit select) and (3 sources, HOLD 1, PIPE 1).
// Each build has an expected queue holding what its output pipeline should
// contain; the front of the queue is what the ports must show.
module tb_cf_fft_stage_mux;

    localparam int EW = 12; // {data[7:0], sync, sel[2:0]}

    // ---------------- clock / reset ----------------
    logic clock_c = 1'b0;
    always #5 clock_c = ~clock_c;

    logic       reset_i;
    logic       enable_i;
    logic       sync_i;
    logic       force_en_i;
    logic [2:0] force_sel_i;
    logic [7:0] ch [4];

    logic [31:0] data0_i;
    logic [23:0] data1_i;
    assign data0_i = {ch[3], ch[2], ch[1], ch[0]};
    assign data1_i = {ch[2], ch[1], ch[0]};

    logic [7:0] data0_o, data1_o;
    logic       sync0_o, sync1_o;
    logic [2:0] sel0_o;
    logic [1:0] sel1_o;

    cf_fft_stage_mux #(.WIDTH(8), .NUM_SRC(4), .HOLD(2), .PIPE(2), .SEL_W(3)) u_dut0 (
        .clock_c    (clock_c),
        .reset_i    (reset_i),
        .enable_i   (enable_i),
        .sync_i     (sync_i),
        .data_i     (data0_i),
        .force_en_i (force_en_i),
        .force_sel_i(force_sel_i),
        .data_o     (data0_o),
        .sync_o     (sync0_o),
        .sel_o      (sel0_o)
    );

    cf_fft_stage_mux #(.WIDTH(8), .NUM_SRC(3), .HOLD(1), .PIPE(1), .SEL_W(2)) u_dut1 (
        .clock_c    (clock_c),
        .reset_i    (reset_i),
        .enable_i   (enable_i),
        .sync_i     (sync_i),
        .data_i     (data1_i),
        .force_en_i (force_en_i),
        .force_sel_i(force_sel_i[1:0]),
        .data_o     (data1_o),
        .sync_o     (sync1_o),
        .sel_o      (sel1_o)
    );

    // ---------------- scoreboard ----------------
    int n_checks = 0;
    int n_errors = 0;

    int n_src  [2] = '{4, 3};
    int hold_n [2] = '{2, 1};
    int pipe_n [2] = '{2, 1};
    int m_hold [2] = '{0, 0};
    int m_sel  [2] = '{0, 0};

    logic [EW-1:0] exp_q0 [$];
    logic [EW-1:0] exp_q1 [$];

    task automatic check_eq(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_checks++;
        if (obs !== exp) begin
            n_errors++;
            $display("FAIL %s: got 0x%0h expected 0x%0h at %0t", tag, obs, exp, $time);
        end
    endtask

    // Expected sample for one build on an enabled edge; advances that build's rotation.
    task automatic model_sample(input int d, output logic [EW-1:0] item);
        int cs, chd, use_idx;
        logic [2:0] fs;
        cs  = sync_i ? 0 : m_sel[d];
        chd = sync_i ? 0 : m_hold[d];
        if (chd == hold_n[d] - 1) begin
            m_hold[d] = 0;
            m_sel[d]  = (cs == n_src[d] - 1) ? 0 : cs + 1;
        end else begin
            m_hold[d] = chd + 1;
            m_sel[d]  = cs;
        end
        fs      = (d == 0) ? force_sel_i : {1'b0, force_sel_i[1:0]};
        use_idx = force_en_i ? int'(fs) : cs;
        if (use_idx >= n_src[d]) use_idx = 0;
        item = {ch[use_idx], sync_i, 3'(use_idx)};
    endtask

    task automatic model_edge();
        logic [EW-1:0] it;
        if (reset_i) begin
            m_hold = '{0, 0};
            m_sel  = '{0, 0};
            exp_q0.delete();
            exp_q1.delete();
            for (int i = 0; i < pipe_n[0]; i++) exp_q0.push_back('0);
            for (int i = 0; i < pipe_n[1]; i++) exp_q1.push_back('0);
        end else if (enable_i) begin
            model_sample(0, it);
            exp_q0.push_back(it);
            void'(exp_q0.pop_front());
            model_sample(1, it);
            exp_q1.push_back(it);
            void'(exp_q1.pop_front());
        end
    endtask

    task automatic check_all();
        check_eq("d0_data", 32'(data0_o), 32'(exp_q0[0][11:4]));
        check_eq("d0_sync", 32'(sync0_o), 32'(exp_q0[0][3]));
        check_eq("d0_sel",  32'(sel0_o),  32'(exp_q0[0][2:0]));
        check_eq("d1_data", 32'(data1_o), 32'(exp_q1[0][11:4]));
        check_eq("d1_sync", 32'(sync1_o), 32'(exp_q1[0][3]));
        check_eq("d1_sel",  32'(sel1_o),  32'(exp_q1[0][2:0]));
    endtask

    // ---------------- driver ----------------
    task automatic step(input logic rst, input logic en, input logic syn,
                        input logic fen, input logic [2:0] fsel);
        reset_i     = rst;
        enable_i    = en;
        sync_i      = syn;
        force_en_i  = fen;
        force_sel_i = fsel;
        @(posedge clock_c);
        model_edge();
        #1;
        check_all();
    endtask

    task automatic set_fixed_channels();
        ch[0] = 8'h11; ch[1] = 8'h22; ch[2] = 8'h33; ch[3] = 8'h44;
    endtask

    // Literal sequences for the first frame after reset.
    logic [7:0] gold0_d [9] = '{8'h11, 8'h11, 8'h22, 8'h22, 8'h33, 8'h33, 8'h44, 8'h44, 8'h11};
    logic [2:0] gold0_s [9] = '{3'd0, 3'd0, 3'd1, 3'd1, 3'd2, 3'd2, 3'd3, 3'd3, 3'd0};
    logic [7:0] gold1_d [6] = '{8'h11, 8'h22, 8'h33, 8'h11, 8'h22, 8'h33};

    initial begin
        reset_i = 1'b1; enable_i = 1'b0; sync_i = 1'b0;
        force_en_i = 1'b0; force_sel_i = 3'd0;
        set_fixed_channels();

        // Reset, including reset with enable low.
        step(1, 0, 0, 0, 0);
        step(1, 1, 1, 0, 0);

        // Rotation from a sync pulse, with literal expectations.
        for (int i = 0; i < 10; i++) begin
            step(0, 1, (i == 0), 0, 0);
            if (i >= 1) begin
                check_eq("t1_data", 32'(data0_o), 32'(gold0_d[i-1]));
                check_eq("t1_sel",  32'(sel0_o),  32'(gold0_s[i-1]));
                check_eq("t1_sync", 32'(sync0_o), 32'(i == 1));
            end
            if (i < 6) check_eq("t6_data", 32'(data1_o), 32'(gold1_d[i]));
        end

        // Sync re-pulse on the 4th sample while ch1 is active.
        for (int i = 0; i < 10; i++) step(0, 1, (i == 0 || i == 3), 0, 0);
        check_eq("t2_data", 32'(data0_o), 32'h33);

        // Enable low for 3 cycles mid-stream.
        for (int i = 0; i < 3; i++) step(0, 1, 0, 0, 0);
        for (int i = 0; i < 3; i++) step(0, 0, (i == 1), 1, 3'd3);
        for (int i = 0; i < 6; i++) step(0, 1, 0, 0, 0);

        // Force to source 2, then to an out-of-range index, then release.
        for (int i = 0; i < 4; i++) step(0, 1, 0, 1, 3'd2);
        check_eq("t4_force2", 32'(data0_o), 32'h33);
        for (int i = 0; i < 3; i++) step(0, 1, 0, 1, 3'd5);
        check_eq("t4_force5_d", 32'(data0_o), 32'h11);
        check_eq("t4_force5_s", 32'(sel0_o), 32'd0);
        for (int i = 0; i < 8; i++) step(0, 1, 0, 0, 0);

        // One-cycle reset mid-stream, no sync afterwards.
        step(1, 1, 0, 0, 0);
        check_eq("t5_rst_data", 32'(data0_o), 32'h0);
        for (int i = 0; i < 6; i++) step(0, 1, 0, 0, 0);

        // Random phase: random channel data and control.
        for (int i = 0; i < 200; i++) begin
            for (int k = 0; k < 4; k++) ch[k] = 8'($urandom_range(0, 255));
            step(($urandom_range(0, 40) == 0),
                 ($urandom_range(0, 5) != 0),
                 ($urandom_range(0, 7) == 0),
                 ($urandom_range(0, 5) == 0),
                 3'($urandom_range(0, 7)));
        end

        $display("Result: errors=%0d of %0d checks", n_errors, n_checks);
        $finish;
    end

endmodule
